// File: rtl/pipe_stall_ctrl_if.sv
// StallBus bundle between the stall controller and the pipeline stages.
// STALL_PERF_CNT_EN adds the stall_cycles performance counter to the bundle.
interface pipe_stall_ctrl_if;
    logic       flush;
    logic       ld_use_req;
    logic       md_req;
    logic       md_is_div;
    logic       mem_stall_req;
    logic [5:0] stall;
    logic       md_start;
    logic       md_done;
    logic       md_abort;
    logic       md_busy;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;

    modport master (
        input  flush, ld_use_req, md_req, md_is_div, mem_stall_req,
        output stall, md_start, md_done, md_abort, md_busy, stall_cycles
    );
    modport slave (
        output flush, ld_use_req, md_req, md_is_div, mem_stall_req,
        input  stall, md_start, md_done, md_abort, md_busy, stall_cycles
    );
`else
    modport master (
        input  flush, ld_use_req, md_req, md_is_div, mem_stall_req,
        output stall, md_start, md_done, md_abort, md_busy
    );
    modport slave (
        output flush, ld_use_req, md_req, md_is_div, mem_stall_req,
        input  stall, md_start, md_done, md_abort, md_busy
    );
`endif
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/sequencing controller: merges flush, memory wait, mult/div occupancy
// and load-use into the StallBus. Optional STALL_PERF_CNT_EN adds a saturating stall counter.
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.master bus
);

    if (MUL_LAT < 1 || MUL_LAT > (2**CNT_W) - 1) begin : g_bad_mul
        $error("MUL_LAT out of range for CNT_W");
    end
    if (DIV_LAT < 1 || DIV_LAT > (2**CNT_W) - 1) begin : g_bad_div
        $error("DIV_LAT out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LDU  = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]       stall_d;
    logic             start_d, done_d, abort_d;

    // Decode in strict priority: flush, memory wait, mult/div, load-use.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_d   = STALL_NONE;
        start_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        if (bus.flush) begin
            abort_d   = (state == BUSY);
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (bus.mem_stall_req) begin
            stall_d = STALL_MEM;
            // Latency keeps running under a memory wait; done is deferred at zero.
            if (state == BUSY && cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        end else if (state == BUSY) begin
            if (cnt != '0) begin
                stall_d = STALL_EX;
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                done_d    = 1'b1;
                state_nxt = IDLE;
            end
        end else if (bus.md_req) begin
            stall_d   = STALL_EX;
            start_d   = 1'b1;
            cnt_nxt   = bus.md_is_div ? DIV_LOAD : MUL_LOAD;
            state_nxt = BUSY;
        end else if (bus.ld_use_req) begin
            stall_d = STALL_LDU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the request inputs.
    assign bus.stall    = rst ? stall_d : STALL_NONE;
    assign bus.md_start = rst & start_d;
    assign bus.md_done  = rst & done_d;
    assign bus.md_abort = rst & abort_d;
    assign bus.md_busy  = (state == BUSY);

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_cnt <= '0;
        else if (bus.stall[0] && perf_cnt != 32'hFFFF_FFFF)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign bus.stall_cycles = perf_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed sequences plus random traffic on two latency
// configurations, checked against a cycle-count reference model.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus0 ();
    pipe_stall_ctrl_if bus1 ();

    pipe_stall_ctrl #(.MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipe_stall_ctrl #(.MUL_LAT(1), .DIV_LAT(4), .CNT_W(6)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: an op is in flight from its launch cycle; it completes on the
    // first cycle at least LAT cycles after launch that is free of flush and memory wait.
    int lat_mul [2] = '{2, 1};
    int lat_div [2] = '{33, 4};
    bit inflight[2];
    int start_cyc[2];
    int cur_lat [2];
    int perf_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic f, lu, mr, dv, ms);
        bus0.flush = f;  bus0.ld_use_req = lu; bus0.md_req = mr;
        bus0.md_is_div = dv; bus0.mem_stall_req = ms;
        bus1.flush = f;  bus1.ld_use_req = lu; bus1.md_req = mr;
        bus1.md_is_div = dv; bus1.mem_stall_req = ms;
    endtask

    task automatic step(input logic f, lu, mr, dv, ms);
        @(posedge clk);
        #1;
        drive(f, lu, mr, dv, ms);
        @(negedge clk);
`ifdef STALL_PERF_CNT_EN
        chk("perf", bus0.stall_cycles, perf_exp);
`endif
        for (int i = 0; i < 2; i++) begin
            logic [5:0] es;
            logic       est, edn, eab, ebs;
            logic [5:0] os;
            logic       ost, odn, oab, obs;
            es = 6'b000000; est = 1'b0; edn = 1'b0; eab = 1'b0;
            ebs = inflight[i];
            if (f) begin
                eab = inflight[i];
                inflight[i] = 1'b0;
            end else if (ms) begin
                es = 6'b011111;
            end else if (inflight[i]) begin
                if (cyc - start_cyc[i] >= cur_lat[i]) begin
                    edn = 1'b1;
                    inflight[i] = 1'b0;
                end else begin
                    es = 6'b001111;
                end
            end else if (mr) begin
                es = 6'b001111;
                est = 1'b1;
                inflight[i] = 1'b1;
                start_cyc[i] = cyc;
                cur_lat[i] = dv ? lat_div[i] : lat_mul[i];
            end else if (lu) begin
                es = 6'b000111;
            end
            if (i == 0) begin
                os = bus0.stall; ost = bus0.md_start; odn = bus0.md_done;
                oab = bus0.md_abort; obs = bus0.md_busy;
                if (es[0]) perf_exp++;
            end else begin
                os = bus1.stall; ost = bus1.md_start; odn = bus1.md_done;
                oab = bus1.md_abort; obs = bus1.md_busy;
            end
            chk($sformatf("stall%0d", i), 32'(os), 32'(es));
            chk($sformatf("start%0d", i), 32'(ost), 32'(est));
            chk($sformatf("done%0d", i), 32'(odn), 32'(edn));
            chk($sformatf("abort%0d", i), 32'(oab), 32'(eab));
            chk($sformatf("busy%0d", i), 32'(obs), 32'(ebs));
        end
        cyc++;
    endtask

    task automatic chk_reset_quiet(input string tag);
        chk({tag, "_stall0"}, 32'(bus0.stall), 32'd0);
        chk({tag, "_stall1"}, 32'(bus1.stall), 32'd0);
        chk({tag, "_pulse0"}, 32'({bus0.md_start, bus0.md_done, bus0.md_abort, bus0.md_busy}), 32'd0);
        chk({tag, "_pulse1"}, 32'({bus1.md_start, bus1.md_done, bus1.md_abort, bus1.md_busy}), 32'd0);
    endtask

    initial begin
        int k;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        chk_reset_quiet("rst_in");
        repeat (3) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Idle after reset, single load-use bubble, then one multiply.
        repeat (5) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("perf_ldu_mul", bus0.stall_cycles, 32'd3);
`endif

        // Divide: done must land 33 cycles after start with no interference.
        step(0, 0, 1, 1, 0);
        for (k = 0; k < 60; k++) begin
            step(0, 0, 0, 0, 0);
            if (bus0.md_done) break;
        end
        chk("div_done_lat", 32'(k + 1), 32'd33);
        step(0, 0, 0, 0, 0);

        // Multiply with memory wait cycles 1-4, done deferred to cycle 5.
        step(0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("mul_mem_done", 32'(bus0.md_done), 32'd1);
        step(0, 0, 0, 0, 0);

        // Divide flushed at cycle 10.
        step(0, 0, 1, 1, 0);
        repeat (9) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("flush_abort", 32'(bus0.md_abort), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("flush_busy", 32'(bus0.md_busy), 32'd0);
        repeat (40) step(0, 0, 0, 0, 0);

        // Random traffic with biased request rates.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 3,  $urandom_range(99) < 30,
                 $urandom_range(99) < 35, $urandom_range(1),
                 $urandom_range(99) < 15);
        end

        // Reset in the middle of a divide: immediate quiet, no abort pulse.
        step(0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        chk_reset_quiet("rst_mid");
        inflight[0] = 1'b0;
        inflight[1] = 1'b0;
        perf_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
